// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and the STATUS record layout
// for the UART APB register front-end.
package uart_pkg;

    // Register byte offsets within the 16-byte window
    localparam logic [3:0] REG_DATA   = 4'h0;
    localparam logic [3:0] REG_STATUS = 4'h4;
    localparam logic [3:0] REG_CTRL   = 4'h8;
    localparam logic [3:0] REG_ERRCLR = 4'hC;

    // STATUS / CTRL bit positions (CTRL enables mirror STATUS)
    localparam int ST_TX_FULL    = 0;
    localparam int ST_TX_EMPTY   = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_RX_EMPTY   = 3;
    localparam int ST_PARITY     = 4;
    localparam int ST_STOP       = 5;
    localparam int ST_BREAK      = 6;
    localparam int ST_OVERFLOW   = 7;
    localparam int ST_RX_TIMEOUT = 8;
    localparam int ST_W          = 9;

    // Sticky flags occupy STATUS[8:4]
    localparam int STICKY_LO = ST_PARITY;
    localparam int STICKY_W  = ST_RX_TIMEOUT - ST_PARITY + 1;

    // STATUS layout, declared MSB first so tx_full lands on bit 0
    typedef struct packed {
        logic rx_timeout;
        logic overflow_err;
        logic break_err;
        logic stop_err;
        logic parity_err;
        logic rx_empty;
        logic rx_full;
        logic tx_empty;
        logic tx_full;
    } uart_status_t;

endpackage

// File: rtl/uart_rx_timeout.sv
// Saturating idle counter for the RX FIFO. It runs while the FIFO holds
// data and nobody pops it; hit is high on the edge the count reaches the
// limit and stays high while it sits saturated there.
module uart_rx_timeout #(
    parameter int RX_TIMEOUT = 1024,
    parameter int TO_CNT_W   = $clog2(RX_TIMEOUT + 1)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_empty,
    input  logic pop,
    output logic hit
);

    localparam logic [TO_CNT_W-1:0] LIMIT = TO_CNT_W'(RX_TIMEOUT);

    logic [TO_CNT_W-1:0] count;
    logic [TO_CNT_W-1:0] count_next;

    // Next count: restart on empty FIFO or pop, otherwise climb to the limit and stay there
    always_comb begin
        count_next = count;
        if (rx_empty || pop) begin
            count_next = '0;
        end else if (count != LIMIT) begin
            count_next = count + TO_CNT_W'(1);
        end
    end

    // Counter register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

    // Looking at the next value lets the sticky flag set on the same edge the count arrives
    assign hit = (count_next == LIMIT);

endmodule

// File: rtl/uart_apb_regs.sv
// APB3 slave register front-end for the UART: pushes bytes into the TX
// FIFO, pops the RX FIFO, and exposes status, sticky receiver errors,
// interrupt enables, an RX idle timeout and one level interrupt.
module uart_apb_regs
    import uart_pkg::*;
#(
    parameter int DATA_SIZE  = 8,
    parameter int PDATA_W    = 32,
    parameter int RX_TIMEOUT = 1024,
    parameter int TO_CNT_W   = $clog2(RX_TIMEOUT + 1)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 psel,
    input  logic                 penable,
    input  logic                 pwrite,
    input  logic [3:0]           paddr,
    input  logic [PDATA_W-1:0]   pwdata,
    output logic [PDATA_W-1:0]   prdata,
    output logic                 pready,
    output logic                 pslverr,
    output logic [DATA_SIZE-1:0] bus_data_in,
    output logic                 write_data,
    input  logic                 tx_full,
    input  logic                 tx_empty,
    input  logic [DATA_SIZE-1:0] bus_data_out,
    output logic                 read_data,
    input  logic                 rx_full,
    input  logic                 rx_empty,
    input  logic                 parity_error,
    input  logic                 stop_error,
    input  logic                 break_error,
    input  logic                 overflow_error,
    output logic                 irq
);

    logic                acc;
    logic                addr_ok;
    logic                do_push;
    logic                do_pop;
    logic                ctrl_wr;
    logic                errclr_wr;
    logic                timeout_hit;
    logic                irq_next;
    logic [ST_W-1:0]     ctrl;
    logic [STICKY_W-1:0] sticky;
    logic [STICKY_W-1:0] sticky_set;
    logic [STICKY_W-1:0] sticky_clr;
    logic [STICKY_W-1:0] sticky_next;
    logic [ST_W-1:0]     status_bits;
    uart_status_t        status;
    logic                unused_pwdata;

    assign pready = 1'b1;

    // Bus decode; side effects only happen in the access phase of a word-aligned address
    assign acc       = psel & penable;
    assign addr_ok   = (paddr[1:0] == 2'b00);
    assign do_push   = acc &  pwrite & (paddr == REG_DATA) & ~tx_full;
    assign do_pop    = acc & ~pwrite & (paddr == REG_DATA) & ~rx_empty;
    assign ctrl_wr   = acc &  pwrite & (paddr == REG_CTRL);
    assign errclr_wr = acc &  pwrite & (paddr == REG_ERRCLR);

    // The only pwdata bits any register consumes are [8:0]
    assign unused_pwdata = ^pwdata[PDATA_W-1:ST_W];

    uart_rx_timeout #(
        .RX_TIMEOUT (RX_TIMEOUT),
        .TO_CNT_W   (TO_CNT_W)
    ) u_rx_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .rx_empty (rx_empty),
        .pop      (read_data),
        .hit      (timeout_hit)
    );

    assign status.tx_full      = tx_full;
    assign status.tx_empty     = tx_empty;
    assign status.rx_full      = rx_full;
    assign status.rx_empty     = rx_empty;
    assign status.parity_err   = sticky[ST_PARITY     - STICKY_LO];
    assign status.stop_err     = sticky[ST_STOP       - STICKY_LO];
    assign status.break_err    = sticky[ST_BREAK      - STICKY_LO];
    assign status.overflow_err = sticky[ST_OVERFLOW   - STICKY_LO];
    assign status.rx_timeout   = sticky[ST_RX_TIMEOUT - STICKY_LO];
    assign status_bits         = status;

    // Sticky update: write-1-to-clear, but a set arriving in the same cycle wins
    always_comb begin
        sticky_set  = {timeout_hit, overflow_error, break_error, stop_error, parity_error};
        sticky_clr  = '0;
        if (errclr_wr) begin
            sticky_clr = pwdata[ST_RX_TIMEOUT:STICKY_LO];
        end
        sticky_next = (sticky & ~sticky_clr) | sticky_set;
    end

    // Interrupt condition, registered below for one cycle of latency
    always_comb begin
        irq_next = (|(ctrl[ST_RX_TIMEOUT:STICKY_LO] & sticky))
                 | (ctrl[ST_RX_EMPTY] & ~rx_empty)
                 | (ctrl[ST_TX_EMPTY] &  tx_empty)
                 | (ctrl[ST_RX_FULL]  &  rx_full)
                 | (ctrl[ST_TX_FULL]  &  tx_full);
    end

    // Read data and error response, combinational within the access phase
    always_comb begin
        prdata  = '0;
        pslverr = 1'b0;
        if (reset_n && acc) begin
            if (!addr_ok) begin
                pslverr = 1'b1;
            end else begin
                case (paddr)
                    REG_DATA: begin
                        if (pwrite) begin
                            pslverr = tx_full;
                        end else if (rx_empty) begin
                            pslverr = 1'b1;
                        end else begin
                            prdata = PDATA_W'(bus_data_out);
                        end
                    end
                    REG_STATUS: begin
                        if (!pwrite) begin
                            prdata = PDATA_W'(status_bits);
                        end
                    end
                    REG_CTRL: begin
                        if (!pwrite) begin
                            prdata = PDATA_W'(ctrl);
                        end
                    end
                    REG_ERRCLR: begin
                        prdata = '0;
                    end
                    default: begin
                        pslverr = 1'b1;
                    end
                endcase
            end
        end
    end

    // FIFO strobes and the TX data latch, issued on the edge that ends the access
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            write_data  <= 1'b0;
            read_data   <= 1'b0;
            bus_data_in <= '0;
        end else begin
            write_data <= do_push;
            read_data  <= do_pop;
            if (do_push) begin
                bus_data_in <= pwdata[DATA_SIZE-1:0];
            end
        end
    end

    // Control, sticky-flag and interrupt registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ctrl   <= '0;
            sticky <= '0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                ctrl <= pwdata[ST_W-1:0];
            end
            sticky <= sticky_next;
            irq    <= irq_next;
        end
    end

endmodule
